// File: rtl/pipo_shift_register.sv
// ============================================================================
// Module      : pipo_shift_register
// Description : Parallel-in/parallel-out register bank with STAGES cascaded
//               stages from B to Q and a valid flag for post-reset data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipo_shift_register #(
  parameter int               WIDTH       = 4,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid
);

  localparam int CNT_W = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STAGES);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    stage_d[0] = B;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Count saturates at STAGES: that is the edge the first real word reaches Q.
  always_comb begin
    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    valid_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VALUE;
      end
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign Q       = stage_q[STAGES-1];
  assign q_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pipo_shift_register.sv
// ============================================================================
// Module      : tb_pipo_shift_register
// Description : Checks a default instance and a WIDTH=8/STAGES=3/A5 instance
//               against a history-queue model of the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipo_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] b4 = 4'h0;
  logic [3:0] q4;
  logic       v4;
  logic [7:0] b8 = 8'h00;
  logic [7:0] q8;
  logic       v8;

  int n_checks = 0;
  int n_fail   = 0;

  pipo_shift_register dut_def (
    .clk     (clk),
    .reset   (reset),
    .B       (b4),
    .Q       (q4),
    .q_valid (v4)
  );

  pipo_shift_register #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'hA5)
  ) dut_wide (
    .clk     (clk),
    .reset   (reset),
    .B       (b8),
    .Q       (q8),
    .q_valid (v8)
  );

  always #5 clk = ~clk;

  // Model: words accepted since the last reset, newest last, capped at the
  // pipeline depth. Q is the oldest once the pipeline is full.
  logic [3:0] h4 [$];
  logic [7:0] h8 [$];

  always @(posedge clk) begin
    if (reset) begin
      h4.delete();
      h8.delete();
    end else begin
      h4.push_back(b4);
      if (h4.size() > 1) void'(h4.pop_front());
      h8.push_back(b8);
      if (h8.size() > 3) void'(h8.pop_front());
    end
  end

  function automatic logic [3:0] exp_q4();
    return (h4.size() == 1) ? h4[0] : 4'h0;
  endfunction
  function automatic logic [7:0] exp_q8();
    return (h8.size() == 3) ? h8[0] : 8'hA5;
  endfunction
  function automatic logic exp_v4();
    return h4.size() == 1;
  endfunction
  function automatic logic exp_v8();
    return h8.size() == 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b4    = 4'h0;
    b8    = 8'h00;
    tick();
    n_checks += 4;
    if (q4 !== 4'h0) begin
      n_fail++; $display("FAIL reset_q4: got %h expected %h", q4, 4'h0);
    end
    if (v4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_v4: got %b expected 0", v4);
    end
    if (q8 !== 8'hA5) begin
      n_fail++; $display("FAIL reset_q8: got %h expected a5", q8);
    end
    if (v8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_v8: got %b expected 0", v8);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [3:0] pats [4] = '{4'b1010, 4'b0011, 4'b1001, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      b4 = pats[i];
      tick();
      n_checks += 3;
      if (q4 !== pats[i]) begin
        n_fail++; $display("FAIL seq_q[%0d]: got %b expected %b", i, q4, pats[i]);
      end
      if (q4 !== exp_q4()) begin
        n_fail++; $display("FAIL seq_model[%0d]: got %b expected %b", i, q4, exp_q4());
      end
      if (v4 !== 1'b1) begin
        n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, v4);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (q4 !== 4'b0110) begin
        n_fail++; $display("FAIL hold[%0d]: got %b expected 0110", i, q4);
      end
    end
    b4 = 4'b0101;
    tick();
    n_checks++;
    if (q4 !== 4'b0101) begin
      n_fail++; $display("FAIL hold_change: got %b expected 0101", q4);
    end
  endtask

  task automatic test_glitch();
    #2 b4 = 4'b1111;
    #3 b4 = 4'b0101;
    n_checks++;
    if (q4 !== 4'b0101) begin
      n_fail++; $display("FAIL glitch_between: got %b expected 0101", q4);
    end
    tick();
    n_checks++;
    if (q4 !== 4'b0101) begin
      n_fail++; $display("FAIL glitch_edge: got %b expected 0101", q4);
    end
  endtask

  task automatic test_reset_midstream();
    b4    = 4'b1111;
    reset = 1'b1;
    tick();
    n_checks += 2;
    if (q4 !== 4'h0) begin
      n_fail++; $display("FAIL midreset_q: got %b expected 0000", q4);
    end
    if (v4 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_v: got %b expected 0", v4);
    end
    reset = 1'b0;
    tick();
    n_checks += 2;
    if (q4 !== 4'b1111) begin
      n_fail++; $display("FAIL midreset_reload: got %b expected 1111", q4);
    end
    if (v4 !== 1'b1) begin
      n_fail++; $display("FAIL midreset_revalid: got %b expected 1", v4);
    end
  endtask

  task automatic test_param();
    logic [7:0] seq [4] = '{8'h3C, 8'h11, 8'h22, 8'h33};
    logic [7:0] eq  [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h11};
    logic       ev  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (q8 !== 8'hA5) begin
      n_fail++; $display("FAIL param_reset: got %h expected a5", q8);
    end
    for (int i = 0; i < 4; i++) begin
      b8 = seq[i];
      tick();
      n_checks += 2;
      if (q8 !== eq[i]) begin
        n_fail++; $display("FAIL param_q[%0d]: got %h expected %h", i, q8, eq[i]);
      end
      if (v8 !== ev[i]) begin
        n_fail++; $display("FAIL param_v[%0d]: got %b expected %b", i, v8, ev[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      b4    = 4'($urandom);
      b8    = 8'($urandom);
      reset = ($urandom_range(0, 19) == 0);
      tick();
      n_checks += 4;
      if (q4 !== exp_q4()) begin
        n_fail++; $display("FAIL rand_q4[%0d]: got %h expected %h", i, q4, exp_q4());
      end
      if (v4 !== exp_v4()) begin
        n_fail++; $display("FAIL rand_v4[%0d]: got %b expected %b", i, v4, exp_v4());
      end
      if (q8 !== exp_q8()) begin
        n_fail++; $display("FAIL rand_q8[%0d]: got %h expected %h", i, q8, exp_q8());
      end
      if (v8 !== exp_v8()) begin
        n_fail++; $display("FAIL rand_v8[%0d]: got %b expected %b", i, v8, exp_v8());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_glitch();
    test_reset_midstream();
    test_param();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
